// File: rtl/coord_mem_pkg.sv
// Shared definitions for the coordinate-memory arbiter: memory ids, default widths
// and the read-return tag carried through the latency pipeline.
package coord_mem_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int ID_W_DEF   = 3;
   // Requester index field in the tag; supports up to 16 requesters.
   localparam int TAG_IDX_W  = 4;

   localparam logic [ID_W_DEF-1:0] MEM_ID_XMEM = 3'd0;
   localparam logic [ID_W_DEF-1:0] MEM_ID_YMEM = 3'd1;

   typedef struct packed {
      logic                 valid;
      logic [TAG_IDX_W-1:0] req_idx;
      logic [ID_W_DEF-1:0]  mem_id;
   } rd_tag_t;

endpackage

// File: rtl/coord_mem_arbiter_if.sv
// Requester-side handshake plus the decoder-side master bus of the coordinate
// memory arbiter; the arbiter sits on the slave modport.
interface coord_mem_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 3
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ*ID_W-1:0]   req_mem_id;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;
   logic [ID_W-1:0]           mem_id_master;
   logic [ADDR_W-1:0]         address_master;
   logic [DATA_W-1:0]         data_master;
   logic                      wren_master;
   logic [DATA_W-1:0]         xmem_q;
   logic [DATA_W-1:0]         ymem_q;
   logic                      err_bad_id;

   modport slave (
      input  req, req_we, req_mem_id, req_addr, req_wdata, xmem_q, ymem_q,
      output gnt, rvalid, rdata, mem_id_master, address_master, data_master,
             wren_master, err_bad_id
   );

   modport master (
      output req, req_we, req_mem_id, req_addr, req_wdata, xmem_q, ymem_q,
      input  gnt, rvalid, rdata, mem_id_master, address_master, data_master,
             wren_master, err_bad_id
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the search start sits at
// bit 0, isolate the lowest set bit, rotate the one-hot grant back.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   input  logic               last_vld_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   logic [IDX_W-1:0]   start;
   logic [NUM_REQ-1:0] req_rot;
   logic [NUM_REQ-1:0] gnt_rot;

   // With no grant since reset the search begins at requester 0.
   always_comb begin
      start = '0;
      if (last_vld_i && (last_i != IDX_W'(NUM_REQ - 1)))
         start = last_i + IDX_W'(1);
   end

   assign req_rot = NUM_REQ'({req_i, req_i} >> start);
   assign gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
   assign gnt_o   = NUM_REQ'(({gnt_rot, gnt_rot} << start) >> NUM_REQ);

endmodule

// File: rtl/coord_mem_arbiter.sv
// Shares XMEM/YMEM between requesters: round-robin accept, registered master bus,
// fixed-latency read tag pipeline steering q data back to the issuing requester.
module coord_mem_arbiter
   import coord_mem_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int READ_LATENCY = 1,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int ID_W         = ID_W_DEF
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   coord_mem_arbiter_if.slave bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] gnt;
   logic               acc;
   logic [IDX_W-1:0]   acc_idx;
   logic               sel_we;
   logic [ID_W-1:0]    sel_id;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_bad;

   logic [IDX_W-1:0]   last_q;
   logic               last_vld_q;
   logic [ID_W-1:0]    mem_id_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  data_q;
   logic               wren_q;
   logic               err_q;

   rd_tag_t            tag_push;
   rd_tag_t            tag_out;
   rd_tag_t            pipe_q [READ_LATENCY+1];

   logic [NUM_REQ-1:0] rvalid_d, rvalid_q;
   logic [DATA_W-1:0]  rdata_d,  rdata_q;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i      (bus.req),
      .last_i     (last_q),
      .last_vld_i (last_vld_q),
      .gnt_o      (gnt)
   );

   // Select the fields of the (at most one) granted requester.
   always_comb begin
      acc_idx  = '0;
      sel_we   = 1'b0;
      sel_id   = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            acc_idx  = IDX_W'(i);
            sel_we   = bus.req_we[i];
            sel_id   = bus.req_mem_id[i*ID_W +: ID_W];
            sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_data = bus.req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign acc     = |gnt;
   assign sel_bad = sel_id > ID_W'(MEM_ID_YMEM);

   always_comb begin
      tag_push         = '0;
      tag_push.valid   = acc && !sel_we;
      tag_push.req_idx = TAG_IDX_W'(acc_idx);
      tag_push.mem_id  = ID_W_DEF'(sel_id);
   end

   assign tag_out = pipe_q[READ_LATENCY];

   // Tag reaching the last stage lines up with valid q from the memories.
   always_comb begin
      rvalid_d = '0;
      rdata_d  = rdata_q;
      if (tag_out.valid) begin
         for (int i = 0; i < NUM_REQ; i++)
            rvalid_d[i] = (tag_out.req_idx == TAG_IDX_W'(i));
         if (tag_out.mem_id == MEM_ID_XMEM)
            rdata_d = bus.xmem_q;
         else if (tag_out.mem_id == MEM_ID_YMEM)
            rdata_d = bus.ymem_q;
         else
            rdata_d = '0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
         mem_id_q   <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wren_q     <= 1'b0;
         err_q      <= 1'b0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
         for (int i = 0; i <= READ_LATENCY; i++)
            pipe_q[i] <= '0;
      end else begin
         if (acc) begin
            last_q     <= acc_idx;
            last_vld_q <= 1'b1;
            mem_id_q   <= sel_id;
            addr_q     <= sel_addr;
            data_q     <= sel_data;
         end
         wren_q    <= acc && sel_we && !sel_bad;
         err_q     <= err_q | (acc && sel_bad);
         pipe_q[0] <= tag_push;
         for (int i = 1; i <= READ_LATENCY; i++)
            pipe_q[i] <= pipe_q[i-1];
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.gnt            = gnt;
   assign bus.rvalid         = rvalid_q;
   assign bus.rdata          = rdata_q;
   assign bus.mem_id_master  = mem_id_q;
   assign bus.address_master = addr_q;
   assign bus.data_master    = data_q;
   assign bus.wren_master    = wren_q;
   assign bus.err_bad_id     = err_q;

endmodule

// File: doc/coord_mem_arbiter.md
Name: coord_mem_arbiter

Overview:
- Shares the coordinate memories (XMEM mem_id 0, YMEM mem_id 1) between NUM_REQ requesters, e.g. the coordinate collector (writer) and the pathfinding engine (reader).
- Drives the mem_id/address/data/wren master bus into the memory interface decoder.
- Steers XMEM/YMEM read data back to the requester that issued the read.
- Round-robin arbitration with one transaction per cycle; tracks reads through a fixed-latency return pipeline.

Parameters:
- NUM_REQ, 2, number of requesters.
- READ_LATENCY, 1, clocks from the master bus driving an address to valid mem q (pathfinding_mem unregistered output = 1).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- ID_W, 3, mem_id width.

Ports:
- CLOCK_50 input 1 system clock.
- reset_n input 1 asynchronous active-low reset.
- req input NUM_REQ, per-requester request; held until granted.
- req_we input NUM_REQ, 1 = write, 0 = read.
- req_mem_id input NUM_REQ*ID_W, target memory per requester.
- req_addr input NUM_REQ*ADDR_W, address per requester.
- req_wdata input NUM_REQ*DATA_W, write data per requester.
- gnt output NUM_REQ, one-hot combinational grant; transaction accepted in the cycle where req & gnt.
- rvalid output NUM_REQ, one-cycle read-return strobe.
- rdata output DATA_W, read data, shared; qualified by rvalid.
- mem_id_master output ID_W, to decoder.
- address_master output ADDR_W, to decoder.
- data_master output DATA_W, to decoder.
- wren_master output 1, to decoder.
- xmem_q input DATA_W, XMEM q.
- ymem_q input DATA_W, YMEM q.
- err_bad_id output 1, sticky flag: access to mem_id > 1 seen.

Behaviour:
- Reset (async, reset_n = 0):
  - gnt, rvalid, wren_master, err_bad_id = 0.
  - mem_id_master, address_master, data_master, rdata = 0.
  - RR pointer = 0; read pipeline flushed.
- Arbitration (combinational from req and RR pointer):
  - Search starts at the index after the last granted requester and wraps modulo NUM_REQ. After reset, requester 0 has highest priority.
  - At most one gnt bit is high. gnt = 0 when req = 0.
- Accept in cycle t (req[k] & gnt[k]):
  - RR pointer := k at t+1.
  - Master bus registered: at t+1 it carries mem_id/addr/wdata of k, and wren_master = req_we[k] && mem_id <= 1.
- Idle cycle (no accept): wren_master = 0 at t+1; mem_id/address/data hold their previous values.
- Write: no response; complete at t+1.
- Read:
  - Accept pushes {k, mem_id} into a READ_LATENCY+1 deep shift pipeline.
  - At t+1+READ_LATENCY the arbiter samples xmem_q if mem_id = 0, ymem_q if mem_id = 1, else 8'h00.
  - rdata is registered and rvalid[k] pulses at t+2+READ_LATENCY (t+3 by default).
- Throughput: back-to-back accepts every cycle; returns stay in issue order with no stalls.
- Same-address write then read:
  - Write accepted at t, read accepted at t+1: the read returns the new data.
  - Read issued in the same cycle as another requester's write: impossible, one accept per cycle.
- Bad mem_id (> 1): transaction accepted, wren_master forced 0, err_bad_id set from t+1 until reset. A bad-id read still returns rvalid with rdata 8'h00.
- Requester drops req before grant: allowed, nothing issued. Inputs may change freely after the accept cycle.
- Reset mid-operation: in-flight reads are discarded and no rvalid follows; the next accept after reset_n rises is treated as fresh (RR pointer = 0).

Decomposition:
- Shared package coord_mem_pkg:
  - MEM_ID_XMEM = 3'd0, MEM_ID_YMEM = 3'd1.
  - ADDR_W/DATA_W/ID_W defaults.
  - typedef struct rd_tag_t {valid, req_idx, mem_id}.
- Sub-module rr_arbiter: NUM_REQ parameter; inputs req and last-grant pointer; output one-hot gnt. Combinational, reusable.
- Remaining logic stays in coord_mem_arbiter: master register, read tag pipeline, q mux, rdata register, error flag.

Test Plan:
- Single write, then read: req0 writes mem_id 0, addr 8'h05, data 8'h3C at t. Expect wren_master = 1, address 05, data 3C at t+1. req0 then reads addr 05: rvalid[0] pulses 3 clocks after accept with rdata 8'h3C.
- Contention: req0 and req1 held continuously, both reads, req0 to XMEM addr 1 and req1 to YMEM addr 2. Expect gnt alternating 01, 10, 01, 10 starting with req0, one accept per cycle. rvalid returns alternate in issue order with the correct memory's data.
- Back-to-back reads: req1 reads YMEM addrs 0..3 on 4 consecutive cycles (YMEM preloaded 10,11,12,13). Expect rvalid[1] high for 4 consecutive cycles with rdata 10, 11, 12, 13.
- Bad id: req0 writes mem_id 3'd4. Expect wren_master = 0, err_bad_id = 1 from the next cycle and staying high. A read to mem_id 4 returns rvalid with rdata 00.
- Reset mid-flight: issue a read at t, pulse reset_n low at t+1. Expect no rvalid afterwards, all outputs 0, and req1 granted first? No: req0 has priority on the first simultaneous request after reset.
- Idle hold: after a write to addr 8'h7F, no requests for 5 cycles. Expect wren_master = 0 and address_master stays 7F.
